// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// The master side feeds bytes and observes status; the slave side is the loader.
interface imem_loader_if #(
    parameter int N      = 32,
    parameter int ADDR_W = 6
);
    logic              start;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [N-1:0]      wdata;
    logic              busy;
    logic              done;
    logic              error;
    logic              cpu_hold;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        output start, rx_valid, rx_data,
        input  rx_ready, we, waddr, wdata, busy, done, error, cpu_hold, words_loaded
    );

    modport slave (
        input  start, rx_valid, rx_data,
        output rx_ready, we, waddr, wdata, busy, done, error, cpu_hold, words_loaded
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a program into instruction memory from a byte stream: count header,
// MSB-first instruction bytes, XOR checksum. Holds the CPU in reset until done.
module imem_loader #(
    parameter int N      = 32,
    parameter int ADDR_W = 6
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);
    localparam int B     = N / 8;
    localparam int BC_W  = (B > 1) ? $clog2(B) : 1;
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [8:0]      DEPTH     = 9'(2 ** ADDR_W);
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(B - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [BC_W-1:0]   byte_cnt_reg, byte_cnt_next;
    logic [7:0]        csum_reg, csum_next;
    logic [CNT_W-1:0]  words_reg, words_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [N-1:0]      wdata_reg, wdata_next;

    logic              rx_ready_int;
    logic              accept;
    logic              hdr_ok;
    logic [N-1:0]      shifted;
    logic [CNT_W-1:0]  words_inc;

    // Byte lanes move up by one position; the new byte enters at the bottom,
    // so the first byte of a word ends up in the MSB lane.
    generate
        for (genvar gi = 0; gi < B; gi++) begin : g_lane
            if (gi == 0) begin : g_low
                assign shifted[7:0] = bus.rx_data;
            end else begin : g_up
                assign shifted[gi*8 +: 8] = wdata_reg[(gi-1)*8 +: 8];
            end
        end
    endgenerate

    assign rx_ready_int = (state_reg == S_HDR) || (state_reg == S_DATA) ||
                          (state_reg == S_CSUM);
    assign accept       = bus.rx_valid && rx_ready_int;
    assign hdr_ok       = (bus.rx_data != 8'd0) && ({1'b0, bus.rx_data} <= DEPTH);
    assign words_inc    = words_reg + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            addr_reg     <= '0;
            byte_cnt_reg <= '0;
            csum_reg     <= '0;
            words_reg    <= '0;
            count_reg    <= '0;
            wdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            byte_cnt_reg <= byte_cnt_next;
            csum_reg     <= csum_next;
            words_reg    <= words_next;
            count_reg    <= count_next;
            wdata_reg    <= wdata_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        byte_cnt_next = byte_cnt_reg;
        csum_next     = csum_reg;
        words_next    = words_reg;
        count_next    = count_reg;
        wdata_next    = wdata_reg;

        case (state_reg)
            S_IDLE, S_DONE, S_ERROR: begin
                if (bus.start) begin
                    state_next    = S_HDR;
                    addr_next     = '0;
                    byte_cnt_next = '0;
                    csum_next     = '0;
                    words_next    = '0;
                end
            end
            S_HDR: begin
                if (accept) begin
                    if (hdr_ok) begin
                        count_next = CNT_W'(bus.rx_data);
                        state_next = S_DATA;
                    end else begin
                        state_next = S_ERROR;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    wdata_next = shifted;
                    csum_next  = csum_reg ^ bus.rx_data;
                    if (byte_cnt_reg == LAST_BYTE) begin
                        byte_cnt_next = '0;
                        state_next    = S_WRITE;
                    end else begin
                        byte_cnt_next = byte_cnt_reg + BC_W'(1);
                    end
                end
            end
            S_WRITE: begin
                words_next = words_inc;
                // The address stays on the final word so waddr never passes C-1.
                if (words_inc == count_reg) begin
                    state_next = S_CSUM;
                end else begin
                    addr_next  = addr_reg + ADDR_W'(1);
                    state_next = S_DATA;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    state_next = (bus.rx_data == csum_reg) ? S_DONE : S_ERROR;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign bus.rx_ready     = rx_ready_int;
    assign bus.we           = (state_reg == S_WRITE);
    assign bus.waddr        = addr_reg;
    assign bus.wdata        = wdata_reg;
    assign bus.busy         = rx_ready_int || (state_reg == S_WRITE);
    assign bus.done         = (state_reg == S_DONE);
    assign bus.error        = (state_reg == S_ERROR);
    assign bus.cpu_hold     = (state_reg != S_DONE);
    assign bus.words_loaded = words_reg;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad checksum, bad headers, backpressure,
// cycle-level WRITE behaviour, full-depth load and mid-session reset.
module tb_imem_loader;
    localparam int N  = 32;
    localparam int AW = 6;

    logic clk;
    logic reset;

    imem_loader_if #(.N(N), .ADDR_W(AW)) bus ();

    imem_loader #(.N(N), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    int            wcount = 0;
    int            ready_in_write = 0;
    logic [AW-1:0] log_addr [0:511];
    logic [N-1:0]  log_data [0:511];
    logic [N-1:0]  mem_model [0:63];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.we) begin
            log_addr[wcount] = bus.waddr;
            log_data[wcount] = bus.wdata;
            mem_model[bus.waddr] = bus.wdata;
            if (bus.rx_ready) ready_in_write++;
            wcount++;
            $display("write addr=%0d data=%08h", bus.waddr, bus.wdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_session();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int stalls);
        int t;
        for (int s = 0; s < stalls; s++) begin
            bus.rx_valid = 1'b0;
            @(negedge clk);
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        t = 0;
        while (!bus.rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("rx_ready_timeout", 64'(bus.rx_ready), 64'd1);
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_stall);
        for (int k = 3; k >= 0; k--)
            send_byte(w[k*8 +: 8], (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0);
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        while (!(bus.done || bus.error) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("end_timeout", 64'(bus.done || bus.error), 64'd1);
    endtask

    task automatic good_stream();
        send_byte(8'h02, 0);
        send_word(32'hf8000000, 0);
        send_word(32'hcb0e01ce, 0);
        send_byte(8'hf2, 0);
    endtask

    initial begin
        int w0;
        int mism;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);

        check("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
        check("rst_cpu_hold", 64'(bus.cpu_hold), 64'd1);
        check("rst_busy_done_err", {61'd0, bus.busy, bus.done, bus.error}, 64'd0);
        check("rst_wdata", 64'(bus.wdata), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rel_we_waddr", {57'd0, bus.we, bus.waddr}, 64'd0);
        check("rel_words", 64'(bus.words_loaded), 64'd0);

        // 1: two words, good checksum
        w0 = wcount;
        start_session();
        check("t1_busy", 64'(bus.busy), 64'd1);
        good_stream();
        wait_end();
        check("t1_nwrites", 64'(wcount - w0), 64'd2);
        check("t1_addr0", 64'(log_addr[w0]), 64'd0);
        check("t1_data0", 64'(log_data[w0]), 64'hf8000000);
        check("t1_addr1", 64'(log_addr[w0+1]), 64'd1);
        check("t1_data1", 64'(log_data[w0+1]), 64'hcb0e01ce);
        check("t1_done", 64'(bus.done), 64'd1);
        check("t1_cpu_hold", 64'(bus.cpu_hold), 64'd0);
        check("t1_words", 64'(bus.words_loaded), 64'd2);
        check("t1_error", 64'(bus.error), 64'd0);
        $display("session 1 complete");

        // 2: bad checksum, then recovery
        w0 = wcount;
        start_session();
        send_byte(8'h02, 0);
        send_word(32'hf8000000, 0);
        send_word(32'hcb0e01ce, 0);
        send_byte(8'h00, 0);
        wait_end();
        check("t2_nwrites", 64'(wcount - w0), 64'd2);
        check("t2_error", 64'(bus.error), 64'd1);
        check("t2_done", 64'(bus.done), 64'd0);
        check("t2_cpu_hold", 64'(bus.cpu_hold), 64'd1);
        start_session();
        good_stream();
        wait_end();
        check("t2_recover_done", 64'(bus.done), 64'd1);
        $display("session 2 complete");

        // 3: illegal headers
        w0 = wcount;
        start_session();
        send_byte(8'h00, 0);
        check("t3_c0_error", 64'(bus.error), 64'd1);
        check("t3_c0_words", 64'(bus.words_loaded), 64'd0);
        start_session();
        send_byte(8'h41, 0);
        check("t3_c41_error", 64'(bus.error), 64'd1);
        check("t3_c41_words", 64'(bus.words_loaded), 64'd0);
        check("t3_c41_cpu_hold", 64'(bus.cpu_hold), 64'd1);
        @(negedge clk);
        check("t3_nwrites", 64'(wcount - w0), 64'd0);
        $display("session 3 complete");

        // 4: random backpressure, C=1
        w0 = wcount;
        start_session();
        send_byte(8'h01, int'($urandom_range(0, 3)));
        send_word(32'h12345678, 3);
        send_byte(8'h08, int'($urandom_range(0, 3)));
        wait_end();
        check("t4_nwrites", 64'(wcount - w0), 64'd1);
        check("t4_addr", 64'(log_addr[w0]), 64'd0);
        check("t4_data", 64'(log_data[w0]), 64'h12345678);
        check("t4_done", 64'(bus.done), 64'd1);
        $display("session 4 complete");

        // 5: cycle-exact, rx_valid held through WRITE, start pulsed mid-load
        bus.start = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h01;
        check("t5_hdr_ready", 64'(bus.rx_ready), 64'd1);
        @(negedge clk);
        bus.rx_data = 8'h12;
        @(negedge clk);
        bus.rx_data = 8'h34;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.rx_data = 8'h56;
        @(negedge clk);
        bus.rx_data = 8'h78;
        @(negedge clk);
        check("t5_we", 64'(bus.we), 64'd1);
        check("t5_write_ready", 64'(bus.rx_ready), 64'd0);
        check("t5_waddr", 64'(bus.waddr), 64'd0);
        check("t5_wdata", 64'(bus.wdata), 64'h12345678);
        bus.rx_data = 8'h08;
        @(negedge clk);
        check("t5_csum_ready", 64'(bus.rx_ready), 64'd1);
        check("t5_csum_not_done", {62'd0, bus.busy, bus.done}, 64'd2);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        check("t5_done", 64'(bus.done), 64'd1);
        check("t5_words", 64'(bus.words_loaded), 64'd1);
        $display("session 5 complete");

        // 6: full depth, word i = i, checksum of all bytes is 00
        w0 = wcount;
        start_session();
        send_byte(8'h40, 0);
        for (int i = 0; i < 64; i++) send_word(32'(i), 0);
        send_byte(8'h00, 0);
        wait_end();
        check("t6_nwrites", 64'(wcount - w0), 64'd64);
        check("t6_last_addr", 64'(log_addr[w0+63]), 64'd63);
        check("t6_last_data", 64'(log_data[w0+63]), 64'h0000003f);
        check("t6_words", 64'(bus.words_loaded), 64'd64);
        check("t6_done", 64'(bus.done), 64'd1);
        mism = 0;
        for (int i = 0; i < 64; i++) if (mem_model[i] !== 32'(i)) mism++;
        check("t6_mem_contents", 64'(mism), 64'd0);
        check("ready_in_write", 64'(ready_in_write), 64'd0);
        $display("session 6 full load complete");

        // 6b: reset after word 10 with a partial word pending
        w0 = wcount;
        start_session();
        send_byte(8'h40, 0);
        for (int i = 0; i < 10; i++) send_word(32'(i), 0);
        send_byte(8'haa, 0);
        send_byte(8'hbb, 0);
        reset = 1'b1;
        #1;
        check("t6r_cpu_hold", 64'(bus.cpu_hold), 64'd1);
        check("t6r_ready_busy", {62'd0, bus.rx_ready, bus.busy}, 64'd0);
        check("t6r_we_waddr", {57'd0, bus.we, bus.waddr}, 64'd0);
        check("t6r_wdata", 64'(bus.wdata), 64'd0);
        check("t6r_words", 64'(bus.words_loaded), 64'd0);
        check("t6r_nwrites", 64'(wcount - w0), 64'd10);
        @(negedge clk);
        reset        = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hff;
        repeat (10) @(negedge clk);
        bus.rx_valid = 1'b0;
        check("t6r_no_more_writes", 64'(wcount - w0), 64'd10);
        check("t6r_idle", {61'd0, bus.busy, bus.done, bus.error}, 64'd0);
        check("t6r_idle_hold", 64'(bus.cpu_hold), 64'd1);
        $display("session 6 reset complete");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
